// File: rtl/time_counter_if.sv
// rtl/time_counter_if.sv - control inputs and time outputs of the time-of-day counter
interface time_counter_if;
    logic       enable;
    logic       load;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic [5:0] load_seconds;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sec_tick;
    logic       load_err;

    modport slave (
        input  enable, load, load_hours, load_minutes, load_seconds,
        output hours, minutes, seconds, sec_tick, load_err
    );

    modport master (
        output enable, load, load_hours, load_minutes, load_seconds,
        input  hours, minutes, seconds, sec_tick, load_err
    );
endinterface

// File: rtl/time_counter.sv
// rtl/time_counter.sv - prescaled 24-hour hh:mm:ss counter with checked parallel load
module time_counter #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic          clk,
    input  logic          reset,
    time_counter_if.slave bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic          sec_tick_q, sec_tick_d;
    logic          load_err_q, load_err_d;
    logic          load_ok;

    always_comb begin
        presc_d    = presc_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;
        load_ok    = bus.load && (bus.load_hours <= 5'd23) &&
                     (bus.load_minutes <= 6'd59) && (bus.load_seconds <= 6'd59);

        if (bus.enable) begin
            if (presc_q == PRESC_MAX) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (seconds_q == 6'd59) begin
                    seconds_d = 6'd0;
                    if (minutes_q == 6'd59) begin
                        minutes_d = 6'd0;
                        hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                    end else begin
                        minutes_d = minutes_q + 6'd1;
                    end
                end else begin
                    seconds_d = seconds_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // An accepted load overrides any coincident advance; a rejected one leaves it alone.
        if (load_ok) begin
            presc_d    = '0;
            hours_d    = bus.load_hours;
            minutes_d  = bus.load_minutes;
            seconds_d  = bus.load_seconds;
            sec_tick_d = 1'b1;
        end else if (bus.load) begin
            load_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.hours    = hours_q;
    assign bus.minutes  = minutes_q;
    assign bus.seconds  = seconds_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - scoreboard bench for time_counter at TICK_DIV=4 and TICK_DIV=1
module tb_time_counter;
    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       tick;
        logic       err;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ticks1 = 0;
    ev_t  exp_q[$];

    time_counter_if bus4 ();
    time_counter_if bus1 ();

    time_counter #(.TICK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    time_counter #(.TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int h, input int m, input int s, input logic t, input logic e);
        ev_t ev;
        ev.h = 5'(h); ev.m = 6'(m); ev.s = 6'(s); ev.tick = t; ev.err = e;
        exp_q.push_back(ev);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        bus4.load = 1'b1;
        bus4.load_hours = 5'(h);
        bus4.load_minutes = 6'(m);
        bus4.load_seconds = 6'(s);
    endtask

    function automatic logic [31:0] hms(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        return {15'd0, h, m, s};
    endfunction

    // Monitor: every output event of dut4 must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && (bus4.sec_tick || bus4.load_err)) begin
            ev_t got;
            got = '{bus4.hours, bus4.minutes, bus4.seconds, bus4.sec_tick, bus4.load_err};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got %0d:%0d:%0d tick=%0b err=%0b, required no event",
                         got.h, got.m, got.s, got.tick, got.err);
            end else begin
                ev_t want;
                want = exp_q.pop_front();
                if (got === want) n_pass++;
                else $display("FAIL event: got %0d:%0d:%0d tick=%0b err=%0b, required %0d:%0d:%0d tick=%0b err=%0b",
                              got.h, got.m, got.s, got.tick, got.err,
                              want.h, want.m, want.s, want.tick, want.err);
            end
        end
    end

    always @(negedge clk) if (bus1.sec_tick) ticks1++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus4.enable = 1'b0; bus4.load = 1'b0;
        bus4.load_hours = '0; bus4.load_minutes = '0; bus4.load_seconds = '0;
        bus1.enable = 1'b0; bus1.load = 1'b0;
        bus1.load_hours = '0; bus1.load_minutes = '0; bus1.load_seconds = '0;

        // Reset state, then first tick on the 4th enabled edge.
        tick(2);
        check("reset_time", hms(bus4.hours, bus4.minutes, bus4.seconds), hms(0, 0, 0));
        check("reset_tick", 32'(bus4.sec_tick), 0);
        check("reset_err", 32'(bus4.load_err), 0);
        reset = 1'b0; bus4.enable = 1'b1;
        push(0, 0, 1, 1, 0);
        tick(6);

        // Asynchronous reset mid-count.
        #2 reset = 1'b1;
        #1;
        check("async_reset_time", hms(bus4.hours, bus4.minutes, bus4.seconds), hms(0, 0, 0));
        check("async_reset_tick", 32'(bus4.sec_tick), 0);
        tick(1);
        reset = 1'b0;
        tick(3);
        check("no_early_tick", hms(bus4.hours, bus4.minutes, bus4.seconds), hms(0, 0, 0));
        push(0, 0, 1, 1, 0);
        tick(1);

        // Midnight and hour wrap.
        do_load(23, 59, 59); push(23, 59, 59, 1, 0);
        tick(1); bus4.load = 1'b0;
        push(0, 0, 0, 1, 0);
        tick(4);
        do_load(10, 59, 59); push(10, 59, 59, 1, 0);
        tick(1); bus4.load = 1'b0;
        push(11, 0, 0, 1, 0);
        tick(4);

        // Load coincident with prescaler terminal count wins; advance discarded.
        tick(3);
        do_load(12, 34, 56); push(12, 34, 56, 1, 0);
        tick(1); bus4.load = 1'b0;
        push(12, 34, 57, 1, 0);
        tick(4);

        // Illegal loads; the last coincides with an advance.
        do_load(24, 0, 0); push(12, 34, 57, 0, 1);
        tick(1); bus4.load = 1'b0;
        tick(1);
        do_load(5, 60, 0); push(12, 34, 57, 0, 1);
        tick(1); bus4.load = 1'b0;
        do_load(5, 0, 60); push(12, 34, 58, 1, 1);
        tick(1); bus4.load = 1'b0;
        push(12, 34, 59, 1, 0);
        tick(4);

        // Enable gating at prescaler=2.
        tick(2);
        bus4.enable = 1'b0;
        tick(10);
        check("frozen_time", hms(bus4.hours, bus4.minutes, bus4.seconds), hms(12, 34, 59));
        check("frozen_tick", 32'(bus4.sec_tick), 0);
        bus4.enable = 1'b1;
        push(12, 35, 0, 1, 0);
        tick(1);
        check("reenable_first_edge", hms(bus4.hours, bus4.minutes, bus4.seconds), hms(12, 34, 59));
        tick(1);
        check("reenable_second_edge", hms(bus4.hours, bus4.minutes, bus4.seconds), hms(12, 35, 0));
        bus4.enable = 1'b0;
        do_load(7, 8, 9); push(7, 8, 9, 1, 0);
        tick(1); bus4.load = 1'b0;
        tick(3);
        check("disabled_load_time", hms(bus4.hours, bus4.minutes, bus4.seconds), hms(7, 8, 9));
        bus4.enable = 1'b1;
        push(7, 8, 10, 1, 0);
        tick(4);
        bus4.enable = 1'b0;

        // TICK_DIV=1: one second per enabled edge.
        ticks1 = 0;
        bus1.enable = 1'b1;
        tick(1);
        check("div1_first_edge", hms(bus1.hours, bus1.minutes, bus1.seconds), hms(0, 0, 1));
        tick(3599);
        bus1.enable = 1'b0;
        tick(1);
        check("div1_final_time", hms(bus1.hours, bus1.minutes, bus1.seconds), hms(1, 0, 0));
        check("div1_tick_count", 32'(ticks1), 3600);
        check("div1_idle_tick", 32'(bus1.sec_tick), 0);

        tick(2);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
